button_conditioner: RTL and testbench
=====================================

# button_conditioner

Input-conditioning stage between the board push-buttons and the consumers of button state: the LED logic and the Nios PIO `buttons` export. It synchronizes the raw active-low button pins into `sys_clk_50m`, debounces each one independently and presents clean active-high levels. It also produces single-cycle press and release pulses, so downstream logic and software never see contact bounce or metastable samples.

## Interface

**Parameters**
- `N_BUTTONS`, default 4: number of independent button channels.
- `CLK_HZ`, default 50_000_000: clock frequency in Hz.
- `DEBOUNCE_MS`, default 10: required stable time before a level change is accepted.
- `LONG_PRESS_MS`, default 1000: hold time for a long-press event. Used only with `BTN_LONG_PRESS_EN`.

**Ports**
- `sys_clk_50m` input, 1 bit: single system clock; all logic is in this domain.
- `sys_rst_n` input, 1 bit: asynchronous, active-low reset.
- `buttons_raw_n` input, `N_BUTTONS` bits: raw pin levels, asynchronous; 0 means pressed.
- `pressed` output, `N_BUTTONS` bits: debounced level; 1 means pressed.
- `press_pulse` output, `N_BUTTONS` bits: 1-cycle strobe on an accepted press.
- `release_pulse` output, `N_BUTTONS` bits: 1-cycle strobe on an accepted release.
- `long_press` output, `N_BUTTONS` bits: 1-cycle strobe when the hold time is reached.

## Operation

**Derived constants**
- `DEB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS`. Elaboration error if `DEB_CYCLES < 2`.
- `LONG_CYCLES = CLK_HZ/1000*LONG_PRESS_MS`. Elaboration error if `LONG_CYCLES <= DEB_CYCLES`.
- Counter widths are `$clog2(limit+1)`. Counters never wrap.

**Per channel, fully independent**
- Synchronizer: two flops on the inverted pin, giving `sync` (1 = pressed). Both flops reset to 0, meaning released.
- Two-state machine, `RELEASED` / `PRESSED`, with a debounce counter `dcnt`:
  - `sync` equal to the current state: `dcnt` is cleared to 0.
  - `sync` differs and `dcnt < DEB_CYCLES-1`: `dcnt` increments.
  - `sync` differs and `dcnt == DEB_CYCLES-1`: state toggles on that edge and `dcnt` is cleared.
- Any single-cycle agreement between `sync` and the current state restarts the debounce window. A glitch shorter than `DEB_CYCLES` cycles never changes state.
- `pressed` equals the state.
- `press_pulse` is 1 for exactly the one cycle after a `RELEASED`→`PRESSED` toggle; `release_pulse` likewise for `PRESSED`→`RELEASED`. Both are registered.
- Simultaneous events on different channels are all reported in the same cycle; there is no arbitration.

**Reset**
- All outputs reset to 0, all counters to 0, all states to `RELEASED`.
- Reset asserted mid-debounce or mid-hold discards progress, and no pulse is emitted.
- A button held through reset release is reported as a fresh press after `DEB_CYCLES+2` cycles.

## Timing

- Press latency: raw pin falls and stays low. Synchronizer takes 2 edges, then `DEB_CYCLES` edges of differing samples. `pressed` rises and `press_pulse` is high in the cycle starting `DEB_CYCLES+2` edges after the first capturing edge.
- Release latency is identical.
- `press_pulse` and `release_pulse` are never both high on one channel.
- A minimum of `DEB_CYCLES` cycles separates consecutive pulses on one channel.
- Throughput: one state change per channel per `DEB_CYCLES` cycles, at most.

## Configuration

Macro `BTN_LONG_PRESS_EN` selects long-press detection.

**Defined**
- Each channel has a hold counter, cleared while `RELEASED`, incrementing while `PRESSED`, saturating at `LONG_CYCLES`.
- `long_press` is high for one cycle when the counter reaches `LONG_CYCLES - DEB_CYCLES`, measured from the press toggle, so the total hold from the clean pin edge is `LONG_CYCLES+2` cycles.
- At most one `long_press` pulse per press. Release before that point emits no `long_press`.

**Undefined**
- No hold counter is built.
- The `long_press` port remains and is tied to 0.

## Structure

- Package `button_pkg` holds:
  - the function `ms_to_cycles(clk_hz, ms)`;
  - the enum `btn_state_t {RELEASED, PRESSED}`;
  - the elaboration-check helpers.
- Sub-module `button_debounce_ch` is one channel: synchronizer, state machine, debounce counter, optional hold counter, pulse registers.
- `button_conditioner` instantiates `N_BUTTONS` copies in a generate loop and packs the outputs.

## Test plan

Bench parameters: `CLK_HZ=10_000`, `DEBOUNCE_MS=1` (`DEB_CYCLES=10`), `LONG_PRESS_MS=5` (`LONG_CYCLES=50`).

1. **Clean press.** Drive `buttons_raw_n[0]` 1→0 and hold. `pressed[0]` rises and `press_pulse[0]` is high for one cycle, 12 edges later. Other bits stay 0.
2. **Bounce.** Drive 0 for 9 cycles, 1 for 1 cycle, repeated 5 times. `pressed` never rises. Then hold 0: press is reported 12 edges after the last 1→0 transition.
3. **Release.** From `PRESSED`, drive the pin 0→1. `release_pulse` is high for one cycle and `pressed` falls 12 edges later. `press_pulse` stays 0.
4. **All channels.** Drive `buttons_raw_n` 4'b1111→4'b0000 on the same edge. `press_pulse`=4'b1111 in a single cycle.
5. **Reset mid-debounce.** Press, assert `sys_rst_n`=0 at cycle 6, deassert with the pin still 0. All outputs are 0 during reset. The press is reported 12 edges after reset release, with no extra pulses.
6. **Long press, with `BTN_LONG_PRESS_EN`.** Hold 60 cycles: one `long_press` pulse 52 edges after the pin edge. Hold 40 cycles then release: no `long_press`. Without the macro, `long_press` is constant 0.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioning slice.
// Optional feature macro: BTN_LONG_PRESS_EN (long-press detection).
package button_pkg;

  // Debounced level of one button channel.
  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } btn_state_t;

  // Single-cycle event strobes produced on an accepted level change.
  typedef struct packed {
    logic press;
    logic rel;
  } btn_evt_t;

  localparam int unsigned MS_PER_S      = 32'd1000;
  localparam int unsigned MIN_DEB_CYCLES = 32'd2;

  // Converts a duration in milliseconds to a number of clock cycles.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / MS_PER_S) * ms;
  endfunction

  // The debounce window needs at least two cycles to be meaningful.
  function automatic bit deb_cycles_ok(input int unsigned deb_cycles);
    return deb_cycles >= MIN_DEB_CYCLES;
  endfunction

  // The long-press point must lie strictly after the press is accepted.
  function automatic bit long_cycles_ok(input int unsigned long_cycles,
                                        input int unsigned deb_cycles);
    return long_cycles > deb_cycles;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Per-channel button bundle: raw pin in, conditioned level and strobes out.
// The channel logic is the master; consumers of button state use slave.
interface button_conditioner_if;

  logic raw_n;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  modport master (
    input  raw_n,
    output pressed,
    output press_pulse,
    output release_pulse,
    output long_press
  );

  modport slave (
    output raw_n,
    input  pressed,
    input  press_pulse,
    input  release_pulse,
    input  long_press
  );

endinterface

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchronizer, RELEASED/PRESSED debounce FSM,
// registered press/release strobes and, with BTN_LONG_PRESS_EN, a hold
// counter that emits one long_press strobe per press.
module button_debounce_ch
  import button_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 10,
  parameter int unsigned LONG_CYCLES = 50
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.master ch
);

  localparam int unsigned DCNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYCLES - 1);

  // Reject parameter sets that make the debounce or hold timing meaningless.
  if (!deb_cycles_ok(DEB_CYCLES)) begin : g_deb_chk
    $error("button_debounce_ch: DEB_CYCLES must be at least 2");
  end
  if (!long_cycles_ok(LONG_CYCLES, DEB_CYCLES)) begin : g_long_chk
    $error("button_debounce_ch: LONG_CYCLES must exceed DEB_CYCLES");
  end

  logic              sync_meta_q;
  logic              sync_q;
  btn_state_t        sync_state;
  btn_state_t        state_q;
  btn_state_t        state_d;
  logic [DCNT_W-1:0] dcnt_q;
  logic [DCNT_W-1:0] dcnt_d;
  btn_evt_t          evt_q;
  btn_evt_t          evt_d;

  // Bring the inverted (active-high) pin into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= ~ch.raw_n;
      sync_q      <= sync_meta_q;
    end
  end

  // Debounce state, counter and event strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      dcnt_q  <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      evt_q   <= evt_d;
    end
  end

  // Accept a level change only after DEB_CYCLES consecutive differing samples;
  // any agreeing sample restarts the window.
  always_comb begin
    state_d    = state_q;
    dcnt_d     = '0;
    evt_d      = '0;
    sync_state = sync_q ? PRESSED : RELEASED;
    if (sync_state != state_q) begin
      if (dcnt_q == DCNT_LAST) begin
        state_d   = sync_state;
        evt_d.press = (sync_state == PRESSED);
        evt_d.rel   = (sync_state == RELEASED);
      end else begin
        dcnt_d = dcnt_q + DCNT_W'(1);
      end
    end
  end

  assign ch.pressed       = (state_q == PRESSED);
  assign ch.press_pulse   = evt_q.press;
  assign ch.release_pulse = evt_q.rel;

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned HCNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(LONG_CYCLES);
  localparam logic [HCNT_W-1:0] HCNT_FIRE = HCNT_W'(LONG_CYCLES - DEB_CYCLES - 1);

  logic [HCNT_W-1:0] hcnt_q;
  logic [HCNT_W-1:0] hcnt_d;
  logic              long_q;
  logic              long_d;

  // Hold counter runs only while the press persists; the cycle the release is
  // accepted already clears it so a release can never coincide with a strobe.
  always_comb begin
    hcnt_d = '0;
    long_d = 1'b0;
    if ((state_q == PRESSED) && (state_d == PRESSED)) begin
      hcnt_d = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + HCNT_W'(1);
      long_d = (hcnt_q == HCNT_FIRE);
    end
  end

  // Hold counter and long-press strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      long_q <= long_d;
    end
  end

  assign ch.long_press = long_q;
`else
  assign ch.long_press = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BUTTONS raw active-low push-buttons into debounced active-high
// levels plus press/release (and optional long-press) strobes.
// Optional feature macro: BTN_LONG_PRESS_EN.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_BUTTONS     = 4,
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned DEBOUNCE_MS   = 10,
  parameter int unsigned LONG_PRESS_MS = 1000
) (
  input  logic                 sys_clk_50m,
  input  logic                 sys_rst_n,
  input  logic [N_BUTTONS-1:0] buttons_raw_n,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] long_press
);

  localparam int unsigned DEB_CYCLES  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_PRESS_MS);

  // Independent channels, no arbitration between them.
  for (genvar i = 0; i < int'(N_BUTTONS); i++) begin : g_ch
    button_conditioner_if ch_if ();

    assign ch_if.raw_n = buttons_raw_n[i];

    button_debounce_ch #(
      .DEB_CYCLES  (DEB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES)
    ) u_ch (
      .clk   (sys_clk_50m),
      .rst_n (sys_rst_n),
      .ch    (ch_if)
    );

    assign pressed[i]       = ch_if.pressed;
    assign press_pulse[i]   = ch_if.press_pulse;
    assign release_pulse[i] = ch_if.release_pulse;
    assign long_press[i]    = ch_if.long_press;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with CLK_HZ=10_000, DEBOUNCE_MS=1 (10 cycles),
// LONG_PRESS_MS=5 (50 cycles). Honours BTN_LONG_PRESS_EN.
module tb_button_conditioner;

  localparam int unsigned N = 4;
`ifdef BTN_LONG_PRESS_EN
  localparam logic LP = 1'b1;
`else
  localparam logic LP = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] pressed;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
  } exp_t;

  typedef struct {
    string        name;
    logic         rst_n;
    logic [N-1:0] raw_n;
    int unsigned  hold;
    exp_t         exp;
  } vec_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] raw_n = '1;
  logic [N-1:0] pressed;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_press;

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  exp_t sb[$];
  int   n_press [N] = '{default: 0};
  int   n_rel   [N] = '{default: 0};
  int   n_long0     = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BUTTONS     (N),
    .CLK_HZ        (10_000),
    .DEBOUNCE_MS   (1),
    .LONG_PRESS_MS (5)
  ) dut (
    .sys_clk_50m   (clk),
    .sys_rst_n     (rst_n),
    .buttons_raw_n (raw_n),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  // Channel-0 view used by the pulse monitor.
  button_conditioner_if mon_if ();
  assign mon_if.raw_n         = raw_n[0];
  assign mon_if.pressed       = pressed[0];
  assign mon_if.press_pulse   = press_pulse[0];
  assign mon_if.release_pulse = release_pulse[0];
  assign mon_if.long_press    = long_press[0];

  // Count every strobe and flag any press/release overlap on a channel.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (press_pulse[i]) n_press[i]++;
      if (release_pulse[i]) n_rel[i]++;
    end
    if (mon_if.long_press) n_long0++;
    if ((press_pulse & release_pulse) != '0) begin
      n_fail++;
      $display("FAIL overlap at %0t: press=%b release=%b, required no common bit",
               $time, press_pulse, release_pulse);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input string nm, input logic r, input logic [N-1:0] raw,
                     input int unsigned h, input logic [N-1:0] pr,
                     input logic [N-1:0] pp, input logic [N-1:0] rp,
                     input logic [N-1:0] lp);
    vec_t v;
    v.name        = nm;
    v.rst_n       = r;
    v.raw_n       = raw;
    v.hold        = h;
    v.exp.pressed = pr;
    v.exp.press   = pp;
    v.exp.rel     = rp;
    v.exp.lng     = lp;
    vecs.push_back(v);
  endtask

  task automatic check_count(input string nm, input int ch, input int got,
                             input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, required %0d", nm, ch, got, want);
    end
  endtask

  initial begin
    exp_t e;
    exp_t got;

    // Reset state and idle.
    add("reset",     1'b0, 4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0);
    add("idle",      1'b1, 4'hF,  5, 4'h0, 4'h0, 4'h0, 4'h0);
    // Clean press on channel 0: reported after 12 edges.
    add("p_pre",     1'b1, 4'hE, 11, 4'h0, 4'h0, 4'h0, 4'h0);
    add("p_edge",    1'b1, 4'hE,  1, 4'h1, 4'h1, 4'h0, 4'h0);
    add("p_after",   1'b1, 4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h0);
    add("p_hold",    1'b1, 4'hE,  5, 4'h1, 4'h0, 4'h0, 4'h0);
    // Release.
    add("r_pre",     1'b1, 4'hF, 11, 4'h1, 4'h0, 4'h0, 4'h0);
    add("r_edge",    1'b1, 4'hF,  1, 4'h0, 4'h0, 4'h1, 4'h0);
    add("r_after",   1'b1, 4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0);
    add("r_idle",    1'b1, 4'hF,  5, 4'h0, 4'h0, 4'h0, 4'h0);
    // Bounce: 9 low / 1 high never gets through.
    for (int k = 0; k < 5; k++) begin
      add("b_low",   1'b1, 4'hE,  9, 4'h0, 4'h0, 4'h0, 4'h0);
      add("b_high",  1'b1, 4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    add("b_pre",     1'b1, 4'hE, 11, 4'h0, 4'h0, 4'h0, 4'h0);
    add("b_edge",    1'b1, 4'hE,  1, 4'h1, 4'h1, 4'h0, 4'h0);
    add("b_rel",     1'b1, 4'hF, 12, 4'h0, 4'h0, 4'h1, 4'h0);
    add("b_idle",    1'b1, 4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0);
    // All channels together.
    add("a_pre",     1'b1, 4'h0, 11, 4'h0, 4'h0, 4'h0, 4'h0);
    add("a_edge",    1'b1, 4'h0,  1, 4'hF, 4'hF, 4'h0, 4'h0);
    add("a_after",   1'b1, 4'h0,  1, 4'hF, 4'h0, 4'h0, 4'h0);
    add("a_rel",     1'b1, 4'hF, 12, 4'h0, 4'h0, 4'hF, 4'h0);
    add("a_idle",    1'b1, 4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0);
    // Reset mid-debounce with the pin held low.
    add("m_deb",     1'b1, 4'hE,  6, 4'h0, 4'h0, 4'h0, 4'h0);
    add("m_rst",     1'b0, 4'hE,  3, 4'h0, 4'h0, 4'h0, 4'h0);
    add("m_pre",     1'b1, 4'hE, 11, 4'h0, 4'h0, 4'h0, 4'h0);
    add("m_edge",    1'b1, 4'hE,  1, 4'h1, 4'h1, 4'h0, 4'h0);
    add("m_after",   1'b1, 4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h0);
    add("m_rel",     1'b1, 4'hF, 12, 4'h0, 4'h0, 4'h1, 4'h0);
    add("m_idle",    1'b1, 4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0);
    // Long hold: strobe 52 edges after the pin edge (only with the feature).
    add("l_pre",     1'b1, 4'hE, 51, 4'h1, 4'h0, 4'h0, 4'h0);
    add("l_edge",    1'b1, 4'hE,  1, 4'h1, 4'h0, 4'h0, {3'b000, LP});
    add("l_after",   1'b1, 4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h0);
    add("l_hold",    1'b1, 4'hE,  8, 4'h1, 4'h0, 4'h0, 4'h0);
    add("l_rel",     1'b1, 4'hF, 12, 4'h0, 4'h0, 4'h1, 4'h0);
    add("l_idle",    1'b1, 4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0);
    // Short hold of 40 cycles: release lands exactly where the strobe would.
    add("s_hold",    1'b1, 4'hE, 40, 4'h1, 4'h0, 4'h0, 4'h0);
    add("s_rel",     1'b1, 4'hF, 12, 4'h0, 4'h0, 4'h1, 4'h0);
    add("s_idle",    1'b1, 4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0);

    foreach (vecs[k]) begin
      rst_n = vecs[k].rst_n;
      raw_n = vecs[k].raw_n;
      sb.push_back(vecs[k].exp);
      repeat (vecs[k].hold) begin
        @(posedge clk);
        #1;
      end
      got.pressed = pressed;
      got.press   = press_pulse;
      got.rel     = release_pulse;
      got.lng     = long_press;
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got pressed=%b press=%b release=%b long=%b, required pressed=%b press=%b release=%b long=%b",
                 vecs[k].name, got.pressed, got.press, got.rel, got.lng,
                 e.pressed, e.press, e.rel, e.lng);
      end
    end

    // Total strobes per channel: no extra or missing pulses anywhere.
    for (int i = 0; i < N; i++) begin
      check_count("press_count", i, n_press[i], (i == 0) ? 6 : 1);
      check_count("release_count", i, n_rel[i], (i == 0) ? 6 : 1);
    end
    check_count("long_count", 0, n_long0, LP ? 1 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
